// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the fetch sequencer.
package fetch_pkg;

   localparam int unsigned OPC_W = 4;

   localparam logic [OPC_W-1:0] OPC_HLT = 4'h0;
   localparam logic [OPC_W-1:0] OPC_JMP = 4'hC;
   localparam logic [OPC_W-1:0] OPC_BRZ = 4'hD;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StIssue,
      StHalt
   } state_e;

endpackage

// File: rtl/fetch_decode.sv
// Control-flow pre-decode of the IR opcode field.
// BRZ recognition exists only when FETCH_BRZ_EN is defined.
module fetch_decode
   import fetch_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic             is_jmp,
   output logic             is_hlt,
   output logic             is_brz
);

   assign is_jmp = (opcode == OPC_JMP);
   assign is_hlt = (opcode == OPC_HLT);

`ifdef FETCH_BRZ_EN
   assign is_brz = (opcode == OPC_BRZ);
`else
   // Without the branch feature 4'hD decodes as an ordinary instruction.
   assign is_brz = 1'b0;
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: reads instructions over req/ack, steers the pc, issues to execute.
// Optional FETCH_BRZ_EN adds the zero_flag input and the BRZ conditional branch.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_addr,
   output logic               pc_inc,
   output logic               pc_load,
   output logic [ADDR_W-1:0]  pc_load_data,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] ir,
   output logic               ir_valid,
   input  logic               ex_ready,
   output logic               halted,
`ifdef FETCH_BRZ_EN
   input  logic               zero_flag,
`endif
   output logic [CNT_W-1:0]   instr_count
);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [ADDR_W-1:0]  target;
   logic               is_jmp, is_hlt, is_brz;
   logic               brz_taken;

   assign target = ir_q[ADDR_W-1:0];

   fetch_decode u_decode (
      .opcode (ir_q[INSTR_W-1 -: OPC_W]),
      .is_jmp (is_jmp),
      .is_hlt (is_hlt),
      .is_brz (is_brz)
   );

`ifdef FETCH_BRZ_EN
   assign brz_taken = is_brz & zero_flag;
`else
   assign brz_taken = 1'b0;
`endif

   // mem_addr is captured on the edge that enters FETCH. On DECODE->FETCH the pc is
   // updating on that same edge, so the value it is about to hold is captured instead.
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      ir_d       = ir_q;
      cnt_d      = cnt_q;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      mem_req    = 1'b0;
      ir_valid   = 1'b0;
      halted     = 1'b0;
      unique case (state_q)
         StIdle: begin
            state_d    = StFetch;
            mem_addr_d = pc_addr;
         end
         StFetch: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_d    = mem_rdata;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (is_jmp || brz_taken) begin
               pc_load    = 1'b1;
               mem_addr_d = target;
               state_d    = StFetch;
            end else if (is_brz) begin
               pc_inc     = 1'b1;
               mem_addr_d = pc_addr + ADDR_W'(1);
               state_d    = StFetch;
            end else if (is_hlt) begin
               state_d = StHalt;
            end else begin
               pc_inc  = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            ir_valid = 1'b1;
            if (ex_ready) begin
               cnt_d      = cnt_q + CNT_W'(1);
               mem_addr_d = pc_addr;
               state_d    = StFetch;
            end
         end
         StHalt: begin
            halted = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         mem_addr_q <= '0;
         ir_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         ir_q       <= ir_d;
         cnt_q      <= cnt_d;
      end
   end

   assign pc_load_data = pc_load ? target : '0;
   assign mem_addr     = mem_addr_q;
   assign ir           = ir_q;
   assign instr_count  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a behavioural pc and memory; honours FETCH_BRZ_EN.
module tb_fetch_ctrl;

   localparam logic [1:0] EV_FETCH = 2'd0;
   localparam logic [1:0] EV_INC   = 2'd1;
   localparam logic [1:0] EV_LOAD  = 2'd2;
   localparam logic [1:0] EV_ISSUE = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] val;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pc;
   logic        pc_inc, pc_load;
   logic [7:0]  pc_load_data;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] ir;
   logic        ir_valid;
   logic        ex_ready;
   logic        halted;
   logic [3:0]  instr_count;
`ifdef FETCH_BRZ_EN
   logic        zero_flag;
`endif

   logic        pc_set;
   logic [7:0]  pc_set_val;
   logic        done;
   int          n_cmp;
   int          n_err;
   int          exp_cnt;
   logic [7:0]  exp_pc;
   ev_t         exp_q[$];

   always #5 clk = ~clk;

   fetch_ctrl #(
      .ADDR_W  (8),
      .INSTR_W (16),
      .CNT_W   (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_addr      (pc),
      .pc_inc       (pc_inc),
      .pc_load      (pc_load),
      .pc_load_data (pc_load_data),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .ir           (ir),
      .ir_valid     (ir_valid),
      .ex_ready     (ex_ready),
      .halted       (halted),
`ifdef FETCH_BRZ_EN
      .zero_flag    (zero_flag),
`endif
      .instr_count  (instr_count)
   );

   // Program counter model reacting to the strobes.
   always @(posedge clk) begin
      if (pc_set)       pc <= pc_set_val;
      else if (pc_load) pc <= pc_load_data;
      else if (pc_inc)  pc <= pc + 8'd1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic sb(input logic [1:0] kind, input logic [31:0] val);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_unexpected: got kind %0d val %h, expected no event (t=%0t)",
                  kind, val, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || e.val !== val) begin
            n_err++;
            $display("FAIL sb_event: got kind %0d val %h, expected kind %0d val %h (t=%0t)",
                     kind, val, e.kind, e.val, $time);
         end
      end
   endtask

   // Monitor: every observable transaction is matched against the expected queue.
   always @(negedge clk) begin
      if (reset && !done) begin
         if (pc_inc && pc_load) chk("strobe_exclusive", 32'({pc_inc, pc_load}), 32'd0);
         if (mem_req && mem_ack) sb(EV_FETCH, 32'(mem_addr));
         if (pc_inc) sb(EV_INC, 32'd0);
         if (pc_load) sb(EV_LOAD, 32'(pc_load_data));
         if (ir_valid && ex_ready) sb(EV_ISSUE, {12'h0, instr_count, ir});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] kind, input logic [31:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // Serve one read: ack after 'waits' idle cycles, checking req/addr stay stable.
   task automatic serve(input int waits, input logic [15:0] data, input logic [7:0] addr);
      int t = 0;
      while (!mem_req && t < 20) begin
         tick();
         t++;
      end
      if (!mem_req) chk("fetch_timeout", 32'(mem_req), 32'd1);
      for (int i = 0; i <= waits; i++) begin
         chk("mem_req_addr_held", {23'h0, mem_req, mem_addr}, {23'h0, 1'b1, addr});
         if (i == waits) begin
            mem_ack   = 1'b1;
            mem_rdata = data;
         end
         tick();
      end
      mem_ack = 1'b0;
   endtask

   // Ordinary instruction with immediate ack and ex_ready high.
   task automatic run_alu(input logic [15:0] data);
      push(EV_FETCH, 32'(exp_pc));
      push(EV_INC, 32'd0);
      push(EV_ISSUE, {12'h0, 4'(exp_cnt), data});
      serve(0, data, exp_pc);
      chk("alu_pc_inc", 32'({pc_inc, pc_load}), 32'b10);
      tick();
      chk("alu_ir_valid", 32'(ir_valid), 32'd1);
      tick();
      chk("alu_count", 32'(instr_count), 32'((exp_cnt + 1) % 16));
      exp_cnt = (exp_cnt + 1) % 16;
      exp_pc  = exp_pc + 8'd1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_err = 0; done = 1'b0;
      reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0; ex_ready = 1'b1;
      pc_set = 1'b1; pc_set_val = 8'd0; exp_cnt = 0;
`ifdef FETCH_BRZ_EN
      zero_flag = 1'b0;
`endif
      tick();
      tick();
      chk("rst_ir", 32'(ir), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_outputs", {23'h0, pc_load_data, mem_req, pc_inc, pc_load, ir_valid, halted},
          32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);

      // Release, one IDLE cycle, then FETCH; reset mid-FETCH with an ack pending.
      pc_set = 1'b0;
      reset  = 1'b1;
      chk("idle_no_req", 32'(mem_req), 32'd0);
      tick();
      chk("fetch_after_idle", 32'(mem_req), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = 16'hC0A7;
      #2 reset = 1'b0;
      #1;
      chk("midreset_outputs", {27'h0, mem_req, ir_valid, pc_inc, pc_load, 1'b0}, 32'd0);
      chk("midreset_count", 32'(instr_count), 32'd0);
      tick();
      chk("midreset_ack_dropped", 32'(ir), 32'd0);
      mem_ack    = 1'b0;
      pc_set     = 1'b1;
      pc_set_val = 8'd5;
      tick();
      pc_set = 1'b0;
      reset  = 1'b1;

      // pc=5, three wait cycles, ex_ready high.
      push(EV_FETCH, 32'd5);
      push(EV_INC, 32'd0);
      push(EV_ISSUE, {12'h0, 4'd0, 16'h1234});
      serve(3, 16'h1234, 8'd5);
      chk("t2_decode_strobes", 32'({pc_inc, pc_load, ir_valid}), 32'b100);
      chk("t2_ir", 32'(ir), 32'h1234);
      tick();
      chk("t2_ir_valid", 32'(ir_valid), 32'd1);
      tick();
      chk("t2_ir_valid_drop", 32'(ir_valid), 32'd0);
      chk("t2_next_fetch", {23'h0, mem_req, mem_addr}, {23'h0, 1'b1, 8'd6});
      chk("t2_count", 32'(instr_count), 32'd1);
      exp_cnt = 1;

      // JMP to 0xA7.
      push(EV_FETCH, 32'd6);
      push(EV_LOAD, 32'hA7);
      serve(0, 16'hC0A7, 8'd6);
      chk("t3_pc_load", {22'h0, pc_load, pc_inc, pc_load_data}, {22'h0, 1'b1, 1'b0, 8'hA7});
      chk("t3_no_ir_valid", 32'(ir_valid), 32'd0);
      tick();
      chk("t3_jump_fetch", {23'h0, mem_req, mem_addr}, {23'h0, 1'b1, 8'hA7});

      // Execute stalls for 5 cycles.
      ex_ready = 1'b0;
      push(EV_FETCH, 32'hA7);
      push(EV_INC, 32'd0);
      push(EV_ISSUE, {12'h0, 4'd1, 16'h1111});
      serve(0, 16'h1111, 8'hA7);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t4_stall", {14'h0, ir_valid, mem_req, ir}, {14'h0, 1'b1, 1'b0, 16'h1111});
         tick();
      end
      ex_ready = 1'b1;
      chk("t4_last", {14'h0, ir_valid, mem_req, ir}, {14'h0, 1'b1, 1'b0, 16'h1111});
      tick();
      chk("t4_after_transfer", {23'h0, mem_req, mem_addr}, {23'h0, 1'b1, 8'hA8});
      chk("t4_count", 32'(instr_count), 32'd2);
      exp_cnt = 2;

`ifdef FETCH_BRZ_EN
      zero_flag = 1'b1;
      push(EV_FETCH, 32'hA8);
      push(EV_LOAD, 32'h10);
      serve(0, 16'hD010, 8'hA8);
      chk("brz_taken", {22'h0, pc_load, pc_inc, pc_load_data}, {22'h0, 1'b1, 1'b0, 8'h10});
      tick();
      chk("brz_taken_fetch", {23'h0, mem_req, mem_addr}, {23'h0, 1'b1, 8'h10});
      zero_flag = 1'b0;
      push(EV_FETCH, 32'h10);
      push(EV_INC, 32'd0);
      serve(0, 16'hD010, 8'h10);
      chk("brz_not_taken", 32'({pc_inc, pc_load}), 32'b10);
      tick();
      chk("brz_nt_fetch", {23'h0, mem_req, mem_addr}, {23'h0, 1'b1, 8'h11});
      chk("brz_not_counted", 32'(instr_count), 32'd2);
      exp_pc = 8'h11;
`else
      push(EV_FETCH, 32'hA8);
      push(EV_INC, 32'd0);
      push(EV_ISSUE, {12'h0, 4'd2, 16'hD010});
      serve(0, 16'hD010, 8'hA8);
      chk("d_as_alu_inc", 32'({pc_inc, pc_load}), 32'b10);
      tick();
      chk("d_as_alu_issue", 32'(ir_valid), 32'd1);
      tick();
      chk("d_as_alu_count", 32'(instr_count), 32'd3);
      exp_cnt = 3;
      exp_pc  = 8'hA9;
`endif

      // Sixteen issues take the 4-bit counter through 15 -> 0.
      for (int i = 0; i < 16; i++) run_alu(16'h1000 + 16'(i));

      // HLT: no further requests or strobes, execute handshake ignored.
      push(EV_FETCH, 32'(exp_pc));
      serve(0, 16'h0000, exp_pc);
      chk("hlt_no_strobe", 32'({pc_inc, pc_load}), 32'd0);
      tick();
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("halted", 32'(halted), 32'd1);
         chk("halt_quiet", 32'({mem_req, pc_inc, pc_load, ir_valid}), 32'd0);
         tick();
      end
      mem_ack = 1'b0;
      reset = 1'b0;
      #1;
      chk("halt_cleared", 32'(halted), 32'd0);
      chk("halt_reset_count", 32'(instr_count), 32'd0);
      chk("halt_reset_ir", 32'(ir), 32'd0);
      done = 1'b1;
      tick();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
